mat_feeder: RTL

- Transmit-side sequencer for the MatUnit systolic array. It owns MatUnit's input interface: load_weight, weight_progress and data_in.
- Accepts an N x N weight matrix and a stream of activation rows over valid/ready handshakes.
- Produces the diagonally skewed lane stimulus MatUnit expects. Lane i is delayed i cycles relative to lane 0.
- Sits between the vector buffer/DMA and MatUnit.

---
 rtl/mat_pkg.sv | 21 ++
 rtl/mat_skew_line.sv | 50 +++++
 rtl/mat_feeder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// mat_pkg: shared types and constants for the MatUnit input sequencer.
//   word_t         - one IEEE-754 single-precision word, carried as raw bits
//   feeder_state_t - sequencer states
//   WORD_ZERO      - all-zero word driven on idle or bubble lanes
//   WORD_ONE       - 1.0f bit pattern
package mat_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_COLLECT = 3'd1,
    S_W_EMIT    = 3'd2,
    S_X_STREAM  = 3'd3,
    S_X_DRAIN   = 3'd4
  } feeder_state_t;

  localparam word_t WORD_ZERO = 32'h0000_0000;
  localparam word_t WORD_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/mat_skew_line.sv
// mat_skew_line: word + valid delay line of DEPTH registers.
//   clock, reset_n - clock and async active-low clear
//   d_in, v_in     - word and valid entering the line
//   d_out, v_out   - the same word and valid, DEPTH cycles later
// DEPTH=0 is a wire; the caller's own stage register then provides the
// only registered delay on that lane.
module mat_skew_line
  import mat_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clock,
  input  logic  reset_n,
  input  word_t d_in,
  input  logic  v_in,
  output word_t d_out,
  output logic  v_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign d_out = d_in;
      assign v_out = v_in;
    end else begin : g_shift
      word_t            data_r [DEPTH];
      logic [DEPTH-1:0] valid_r;

      // Shift word and valid together one stage per cycle.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            data_r[k] <= WORD_ZERO;
          end
          valid_r <= '0;
        end else begin
          data_r[0]  <= d_in;
          valid_r[0] <= v_in;
          for (int k = 1; k < DEPTH; k++) begin
            data_r[k]  <= data_r[k-1];
            valid_r[k] <= valid_r[k-1];
          end
        end
      end

      assign d_out = data_r[DEPTH-1];
      assign v_out = valid_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mat_feeder.sv
// mat_feeder: transmit-side sequencer for the MatUnit systolic array.
// Collects an N x N weight matrix, replays it diagonally skewed while
// load_weight is high, then streams activation rows with the same skew.
//   clock, reset_n          - clock, async active-low reset
//   w_valid/w_ready/w_row   - weight row handshake, lane i = w_row[i]
//   x_valid/x_ready/x_row   - activation row handshake
//   x_last                  - final activation row of a batch
//   load_weight             - high while weights are being emitted
//   weight_progress         - emit cycle index p = 0..2N-1
//   data_in/data_in_valid   - skewed lane words; lane i lags lane 0 by i
//   busy                    - sequencer not idle
module mat_feeder
  import mat_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(2*N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            w_valid,
  output logic            w_ready,
  input  word_t [N-1:0]   w_row,
  input  logic            x_valid,
  output logic            x_ready,
  input  word_t [N-1:0]   x_row,
  input  logic            x_last,
  output logic            load_weight,
  output logic [PW-1:0]   weight_progress,
  output word_t [N-1:0]   data_in,
  output logic [N-1:0]    data_in_valid,
  output logic            busy
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW    = RW'(N-1);
  localparam logic [RW-1:0] ONE_ROW     = RW'(1);
  localparam logic [PW-1:0] N_P         = PW'(N);
  localparam logic [PW-1:0] EMIT_LAST_P = PW'(2*N-2);
  localparam logic [PW-1:0] FINAL_P     = PW'(2*N-1);

  feeder_state_t  state_r, state_nxt_s;
  logic [RW-1:0]  cnt_r, cnt_nxt_s;
  logic           load_weight_r, load_nxt_s;
  logic [PW-1:0]  weight_progress_r, prog_nxt_s;
  logic           w_ready_r, x_ready_r, busy_r;
  word_t [N-1:0]  weights_r [N];
  logic [RW-1:0]  wr_row_s;
  logic           w_acc_s, x_acc_s;
  logic [PW-1:0]  feed_idx_s;
  word_t [N-1:0]  feed_d_s, stage_d_r;
  logic           feed_v_s, stage_v_r;
  word_t          lane_d_s [N];
  logic           lane_v_s [N];

  // Ready flags are registered, so they alone qualify a handshake.
  assign w_acc_s    = w_valid & w_ready_r;
  assign x_acc_s    = x_valid & x_ready_r;
  assign feed_idx_s = weight_progress_r + 1'b1;

  // Next state and shared row/drain counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (w_acc_s) begin
          state_nxt_s = S_W_COLLECT;
          cnt_nxt_s   = ONE_ROW;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_W_COLLECT: begin
        if (w_acc_s && (cnt_r == LAST_ROW)) begin
          state_nxt_s = S_W_EMIT;
          cnt_nxt_s   = '0;
        end else if (w_acc_s) begin
          cnt_nxt_s = cnt_r + 1'b1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_W_EMIT: begin
        // Leave one cycle early: the final emit index is still shown
        // registered while x_ready is already up.
        if (weight_progress_r == EMIT_LAST_P) begin
          state_nxt_s = S_X_STREAM;
        end else begin
          state_nxt_s = S_W_EMIT;
        end
      end
      S_X_STREAM: begin
        if (x_acc_s && x_last) begin
          state_nxt_s = S_X_DRAIN;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = S_X_STREAM;
        end
      end
      S_X_DRAIN: begin
        if (cnt_r == LAST_ROW) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Next values of load_weight / weight_progress.
  always_comb begin
    load_nxt_s = 1'b0;
    prog_nxt_s = '0;
    if (state_nxt_s == S_W_EMIT) begin
      load_nxt_s = 1'b1;
      if (state_r == S_W_EMIT) begin
        prog_nxt_s = feed_idx_s;
      end else begin
        prog_nxt_s = '0;
      end
    end else if ((state_r == S_W_EMIT) && (state_nxt_s == S_X_STREAM)) begin
      load_nxt_s = 1'b1;
      prog_nxt_s = FINAL_P;
    end else begin
      load_nxt_s = 1'b0;
      prog_nxt_s = '0;
    end
  end

  // Row that lane 0's stage loads this cycle; skew lines add the diagonal.
  always_comb begin
    feed_d_s = '0;
    feed_v_s = 1'b0;
    case (state_r)
      S_W_COLLECT: begin
        // Row 0 must enter the stage on the same edge that captures row N-1.
        if (w_acc_s && (cnt_r == LAST_ROW)) begin
          feed_d_s = weights_r[0];
          feed_v_s = 1'b1;
        end else begin
          feed_v_s = 1'b0;
        end
      end
      S_W_EMIT: begin
        if (feed_idx_s < N_P) begin
          feed_d_s = weights_r[feed_idx_s[RW-1:0]];
          feed_v_s = 1'b1;
        end else begin
          feed_v_s = 1'b0;
        end
      end
      S_X_STREAM: begin
        if (x_acc_s) begin
          feed_d_s = x_row;
          feed_v_s = 1'b1;
        end else begin
          feed_v_s = 1'b0;
        end
      end
      default: begin
        feed_v_s = 1'b0;
      end
    endcase
  end

  // Weight-store write row: row 0 from IDLE, else the collect count.
  always_comb begin
    if (state_r == S_IDLE) begin
      wr_row_s = '0;
    end else begin
      wr_row_s = cnt_r;
    end
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= S_IDLE;
      cnt_r             <= '0;
      load_weight_r     <= 1'b0;
      weight_progress_r <= '0;
      w_ready_r         <= 1'b0;
      x_ready_r         <= 1'b0;
      busy_r            <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      cnt_r             <= cnt_nxt_s;
      load_weight_r     <= load_nxt_s;
      weight_progress_r <= prog_nxt_s;
      w_ready_r         <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_W_COLLECT);
      x_ready_r         <= (state_nxt_s == S_X_STREAM);
      busy_r            <= (state_nxt_s != S_IDLE);
    end
  end

  // Weight store: capture each accepted weight row.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N; r++) begin
        weights_r[r] <= '0;
      end
    end else if (w_acc_s) begin
      weights_r[wr_row_s] <= w_row;
    end
  end

  // Lane-0 stage register shared by every lane's skew line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_d_r <= '0;
      stage_v_r <= 1'b0;
    end else begin
      stage_d_r <= feed_d_s;
      stage_v_r <= feed_v_s;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      mat_skew_line #(.DEPTH(gi)) u_skew (
        .clock   (clock),
        .reset_n (reset_n),
        .d_in    (stage_d_r[gi]),
        .v_in    (stage_v_r),
        .d_out   (lane_d_s[gi]),
        .v_out   (lane_v_s[gi])
      );
      assign data_in[gi]       = lane_d_s[gi];
      assign data_in_valid[gi] = lane_v_s[gi];
    end
  endgenerate

  assign w_ready         = w_ready_r;
  assign x_ready         = x_ready_r;
  assign load_weight     = load_weight_r;
  assign weight_progress = weight_progress_r;
  assign busy            = busy_r;

endmodule
